// File: rtl/spi_slave_rx_param.sv
// spi_slave_rx_param
// SPI slave receiver. The SPI pins are synchronized into the i_clk domain, and
// sampling edges are picked from the latched CPOL/CPHA mode. Received words are
// assembled MSB first together with the DC flag and queued for a ready/valid
// consumer.
//
// Configuration macro: SPI_SLAVE_RX_FIFO_EN
//   defined   : circular FIFO of FIFO_DEPTH words
//   undefined : single holding register (FIFO_DEPTH unused)
//
// Ports
//   i_clk, i_rst_n        system clock, synchronous active-low reset
//   i_spi_clk, i_spi_cs   SPI clock and chip select (active-low), asynchronous
//   i_spi_mosi, i_dc      serial data (MSB first) and data/command flag
//   i_cpol, i_cpha        SPI mode, latched when CS falls
//   o_data, o_dc, o_valid head-of-buffer word, its DC flag, valid
//   i_ready               consumer accepts head word when o_valid is high
//   o_overflow            one-cycle pulse when a completed word is dropped
//   o_frame_err           one-cycle pulse when CS rises mid-word
//   o_busy                a frame is in progress (synchronized CS asserted)
module spi_slave_rx_param #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  input  logic              i_dc,
  input  logic              i_cpol,
  input  logic              i_cpha,
  output logic [DATA_W-1:0] o_data,
  output logic              o_dc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if (DATA_W < 8 || DATA_W > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("spi_slave_rx_param: illegal parameter value");
  end

  // ---- synchronizers ----
  // All chains clear to 0. A cleared CS chain reads "asserted", so after
  // reset a frame can only start once CS has been seen high and then low.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, dc_sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], i_dc};
    end
  end

  logic sclk_s, cs_s, mosi_s, dc_s;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // ---- p0: edge detection, mode latch, sample strobe ----
  logic       sclk_prev_q, cs_prev_q, active_q;
  logic [1:0] mode_q;
  logic       vld_p0_q, rise_p0_q, bit_p0_q, dc_p0_q;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, samp_edge;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // CPOL xor CPHA selects the falling edge as the sampling edge.
  assign samp_edge = (mode_q[1] ^ mode_q[0]) ? sclk_fall : sclk_rise;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      active_q    <= 1'b0;
      mode_q      <= 2'b00;
      vld_p0_q    <= 1'b0;
      rise_p0_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (cs_fall) begin
        active_q <= 1'b1;
        mode_q   <= {i_cpol, i_cpha};
      end else if (cs_rise) begin
        active_q <= 1'b0;
      end
      vld_p0_q  <= samp_edge & active_q & ~cs_s;
      rise_p0_q <= cs_rise;
    end
  end

  always_ff @(posedge i_clk) begin
    bit_p0_q <= mosi_s;
    dc_p0_q  <= dc_s;
  end

  // ---- p1: shift register, bit counter, word completion ----
  logic [DATA_W-1:0] shift_q, shift_d, word_p1_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_p1_q, push_p1_d, wdc_p1_q, ferr_d, ferr_q;

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push_p1_d = 1'b0;
    ferr_d    = 1'b0;
    if (rise_p0_q) begin
      // CS rose: a nonzero count means a partial word, which is discarded.
      cnt_d  = '0;
      ferr_d = (cnt_q != '0);
    end else if (!active_q) begin
      cnt_d = '0;
    end else if (vld_p0_q) begin
      shift_d = {shift_q[DATA_W-2:0], bit_p0_q};
      if (cnt_q == LAST_BIT) begin
        cnt_d     = '0;
        push_p1_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      push_p1_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      push_p1_q <= push_p1_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_p1_d) begin
      word_p1_q <= shift_d;
      wdc_p1_q  <= dc_p0_q;
    end
  end

  // ---- p2: receive buffer ----
  logic pop, push_ok, ovf_q;
  assign pop = o_valid & i_ready;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic              mem_dc_q   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full;

  assign full    = (count_q == DEPTH_C);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push_ok = push_p1_q & (~full | pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push_p1_q & full & ~pop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_data_q[wr_ptr_q] <= word_p1_q;
      mem_dc_q[wr_ptr_q]   <= wdc_p1_q;
    end
  end

  assign o_valid = (count_q != '0);
  assign o_data  = o_valid ? mem_data_q[rd_ptr_q] : '0;
  assign o_dc    = o_valid ? mem_dc_q[rd_ptr_q] : 1'b0;
`else
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_dc_q, full_q;

  assign push_ok = push_p1_q & (~full_q | pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q  <= push_p1_q & full_q & ~pop;
      full_q <= push_ok | (full_q & ~pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      hold_data_q <= word_p1_q;
      hold_dc_q   <= wdc_p1_q;
    end
  end

  assign o_valid = full_q;
  assign o_data  = full_q ? hold_data_q : '0;
  assign o_dc    = full_q ? hold_dc_q : 1'b0;
`endif

  assign o_overflow  = ovf_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = active_q;

endmodule
